// File: rtl/ru_pkg.sv
// Shared types and default sizes for the RU access controller.
// The state enum is the one place the controller's states are defined.
package ru_pkg;

    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        DBG_ACK = 2'd3
    } ru_state_t;

endpackage

// File: rtl/ru_clear_seq.sv
// Sweep counter for the register clear: walks x1..x(NREGS-1), flags the last one.
// Wraps back to 1 on completion so every entry into CLEAR starts at x1.
module ru_clear_seq #(
    parameter int NREGS = ru_pkg::NREGS_DEF,
    parameter int AW    = ru_pkg::AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          restart,
    output logic [AW-1:0] addr,
    output logic          done
);

    logic [AW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= AW'(1);
        else if (restart) cnt <= AW'(1);
        else if (en)      cnt <= done ? AW'(1) : cnt + AW'(1);
    end

    assign addr = cnt;
    assign done = (cnt == AW'(NREGS - 1));

endmodule

// File: rtl/ru_access_ctrl.sv
// Arbitrates RU register-file access between the core, a post-reset/on-demand
// clear sweep, and a halt-mode debug port. The RU itself lives in the parent.
module ru_access_ctrl
    import ru_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_ruWr,
    input  logic [AW-1:0] core_rd,
    input  logic [DW-1:0] core_DataWr,
    input  logic [AW-1:0] core_rs1,
    input  logic [AW-1:0] core_rs2,
    output logic          core_stall,
    input  logic          dbg_halt,
    input  logic          dbg_resume,
    input  logic          dbg_clear,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          halted,
    output logic          ruWr,
    output logic [AW-1:0] rd,
    output logic [DW-1:0] DataWr,
    output logic [AW-1:0] rs1,
    output logic [AW-1:0] rs2,
    input  logic [DW-1:0] ruRs1
);

    ru_state_t     state, state_n;
    logic          ret_halt;
    logic          sweep_restart;
    logic          sweep_done;
    logic [AW-1:0] sweep_addr;
    logic          wr_en;
    logic          dbg_rd_cyc;

    ru_clear_seq #(.NREGS(NREGS), .AW(AW)) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state == CLEAR),
        .restart (sweep_restart),
        .addr    (sweep_addr),
        .done    (sweep_done)
    );

    // A held dbg_halt at the end of a sweep lands in HALTED without a RUN cycle.
    always_comb begin
        state_n       = state;
        sweep_restart = 1'b0;
        case (state)
            CLEAR:   if (sweep_done) state_n = (ret_halt || dbg_halt) ? HALTED : RUN;
            RUN:     if (dbg_halt) state_n = HALTED;
            HALTED: begin
                if (dbg_req) begin
                    state_n = DBG_ACK;
                end else if (dbg_clear) begin
                    state_n       = CLEAR;
                    sweep_restart = 1'b1;
                end else if (dbg_resume && !dbg_halt) begin
                    state_n = RUN;
                end
            end
            DBG_ACK: state_n = HALTED;
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            ret_halt <= 1'b0;
        end else begin
            state <= state_n;
            if (sweep_restart)                    ret_halt <= 1'b1;
            else if (state == CLEAR && sweep_done) ret_halt <= 1'b0;
        end
    end

    assign dbg_rd_cyc = (state == HALTED) && dbg_req && !dbg_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          dbg_rdata <= '0;
        else if (dbg_rd_cyc) dbg_rdata <= (dbg_addr == '0) ? '0 : ruRs1;
    end

    always_comb begin
        wr_en  = 1'b0;
        rd     = core_rd;
        DataWr = core_DataWr;
        case (state)
            CLEAR: begin
                wr_en  = 1'b1;
                rd     = sweep_addr;
                DataWr = '0;
            end
            RUN:    wr_en = core_ruWr;
            HALTED: begin
                wr_en  = dbg_req && dbg_we;
                rd     = dbg_addr;
                DataWr = dbg_wdata;
            end
            default: wr_en = 1'b0;
        endcase
    end

    // rst_n gates the strobe so nothing is written while reset is held.
    assign ruWr       = wr_en && (rd != '0) && rst_n;
    assign rs1        = dbg_rd_cyc ? dbg_addr : core_rs1;
    assign rs2        = core_rs2;
    assign core_stall = (state != RUN);
    assign halted     = (state == HALTED) || (state == DBG_ACK);
    assign dbg_ack    = (state == DBG_ACK);

endmodule

// File: doc/ru_access_ctrl.md
RU_ACCESS_CTRL -- requirements
Module: ru_access_ctrl

Interface
REQ-001 Parameters SHALL be: NREGS, default 32, number of RU registers; AW, default 5, register address width; DW, default 32, data width.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_ruWr  in  1  core writeback enable.
- core_rd  in  AW  core writeback address.
- core_DataWr  in  DW  core writeback data.
- core_rs1  in  AW  core read address, port 1.
- core_rs2  in  AW  core read address, port 2.
- core_stall  out  1  core must hold its PC and state.
- dbg_halt  in  1  halt request, level.
- dbg_resume  in  1  resume request, pulse.
- dbg_clear  in  1  re-clear request, pulse, honoured only when HALTED.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  AW  debug register address.
- dbg_wdata  in  DW  debug write data.
- dbg_ack  out  1  one-cycle access-done pulse.
- dbg_rdata  out  DW  registered read data.
- halted  out  1  controller is in HALTED.
- ruWr, rd, DataWr, rs1, rs2  out  1/AW/DW/AW/AW  drive RU.
- ruRs1  in  DW  RU read data, port 1.
REQ-003 The single clock and the asynchronous active-low reset SHALL be named clk and rst_n.

Function
REQ-004 The FSM SHALL have exactly the states CLEAR, RUN, HALTED and DBG_ACK.
REQ-005 CLEAR SHALL sweep x1..x(NREGS-1), one register per cycle, with ruWr=1, DataWr=0 and rd equal to the sweep counter.
- The sweep takes NREGS-1 cycles.
- core_stall SHALL be 1 throughout.
REQ-006 When the sweep completes, CLEAR SHALL go to HALTED if entered via dbg_clear, otherwise to RUN.
REQ-007 In RUN, ruWr/rd/DataWr/rs1/rs2 SHALL pass the core_* inputs through combinationally, with zero-cycle latency.
- core_stall SHALL be 0.
REQ-008 In any state, ruWr SHALL be forced to 0 whenever the selected rd is 0, so x0 is never written.
REQ-009 RUN SHALL go to HALTED on the first edge where dbg_halt=1. A core write in that same cycle SHALL still be performed.
REQ-010 In HALTED and DBG_ACK, core_stall SHALL be 1, halted SHALL be 1, and core writes SHALL be suppressed.
REQ-011 HALTED with dbg_req=1 SHALL perform exactly one access and then go to DBG_ACK.
- Write: ruWr=1, rd=dbg_addr, DataWr=dbg_wdata, in the request cycle.
- Read: rs1=dbg_addr; ruRs1 is captured into dbg_rdata at the same edge.
REQ-012 DBG_ACK SHALL assert dbg_ack for one cycle and return to HALTED.
- No RU write occurs in DBG_ACK.
- The requester SHALL deassert dbg_req in the DBG_ACK cycle; a request still high in the following HALTED cycle is a new access.
REQ-013 A read of x0 SHALL return 0 in dbg_rdata, regardless of ruRs1.
REQ-014 HALTED event priority SHALL be dbg_req, then dbg_clear, then dbg_resume.
- Lower-priority events that coincide with a higher one are dropped.
- dbg_resume SHALL go to RUN only if dbg_halt=0; otherwise it is ignored.
REQ-015 dbg_clear in HALTED SHALL restart the sweep from x1 and SHALL set a return-to-HALTED flag.
REQ-016 dbg_halt, dbg_req, dbg_clear and dbg_resume SHALL be ignored during CLEAR, except that a level-held dbg_halt takes effect after the sweep.
REQ-017 rs2 SHALL always equal core_rs2. rs1 SHALL equal core_rs1 except during a debug read cycle.

Reset
REQ-018 While rst_n=0, state SHALL be CLEAR with sweep counter=1 and return flag=0.
REQ-019 While rst_n=0, dbg_rdata SHALL be 0, dbg_ack SHALL be 0, and halted SHALL be 0.
REQ-020 While rst_n=0, ruWr SHALL be 0 and core_stall SHALL be 1.
REQ-021 The first sweep write SHALL occur in the first cycle after rst_n deasserts.
REQ-022 Reset asserted mid-sweep or mid-access SHALL abort it. A full sweep SHALL restart after deassertion.

Structure
REQ-023 A shared package ru_pkg SHALL hold the state enum (CLEAR, RUN, HALTED, DBG_ACK) and the NREGS/AW/DW defaults.
REQ-024 The RU itself SHALL be instantiated by the parent, not inside this block.
REQ-025 One sub-module, ru_clear_seq, SHALL be used: the sweep counter, producing the current address and a done flag.

Verification
REQ-026 Reset release: exactly 31 consecutive cycles SHALL show ruWr=1, DataWr=0, rd=1..31, then core_stall=0. Every RU register SHALL read 0.
REQ-027 RUN with core_ruWr=1, core_rd=10, core_DataWr=0x67676767: RU x10 SHALL equal 0x67676767 after one edge.
REQ-028 core_rd=0, core_DataWr=0xFFFFFFFF: ruWr SHALL be 0 and x0 SHALL stay 0.
REQ-029 Halt, then debug write x8=0x67676760, then debug read x8:
- dbg_ack SHALL pulse once per access.
- dbg_rdata SHALL be 0x67676760.
- core_stall SHALL be 1 throughout.
REQ-030 In HALTED with x9 nonzero, pulse dbg_clear:
- 31-cycle sweep, then return to HALTED.
- A debug read of x9 SHALL return 0.
REQ-031 Assert rst_n=0 at sweep address 15: ruWr SHALL drop to 0 immediately, and the sweep SHALL restart at rd=1 after release.
